spike_rate_decoder: RTL and testbench

//  Receiving end of the LIF neuron spike output: converts a 1-bit spike train back into a

---
 rtl/spike_codec_pkg.sv | 15 +
 rtl/spike_window_timer.sv | 29 ++
 rtl/spike_rate_decoder.sv | 138 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_codec_pkg.sv
// Shared constants and FSM state type for the spike encoder/decoder family.
// Widths here are the defaults used by the neuron tile and the rate decoder.
package spike_codec_pkg;

  localparam int SPK_WIN_W       = 8;
  localparam int SPK_CNT_W       = 6;
  localparam int SPK_DEFAULT_WIN = 64;
  localparam int SPK_EMA_SHIFT   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/spike_window_timer.sv
// Loadable window down-counter; last is high on the final cycle of a window.
// Reloads itself on the last cycle so windows run back to back.
module spike_window_timer
  import spike_codec_pkg::*;
#(
  parameter int W = SPK_WIN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] reload,
  output logic         last
);

  logic [W-1:0] timer;

  always_ff @(posedge clk) begin
    if (reset)
      timer <= '0;
    else if (load)
      timer <= reload;
    else if (enable)
      timer <= (timer == '0) ? reload : timer - W'(1);
  end

  assign last = enable & (timer == '0);

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike train to rate decoder: counts rising edges per window, valid/ready out.
// Define SPIKE_EMA_EN to smooth the per-window count with a shift-based EMA.
module spike_rate_decoder
  import spike_codec_pkg::*;
#(
  parameter int WIN_W       = SPK_WIN_W,
  parameter int CNT_W       = SPK_CNT_W,
  parameter int DEFAULT_WIN = SPK_DEFAULT_WIN
`ifdef SPIKE_EMA_EN
  ,
  parameter int EMA_SHIFT   = SPK_EMA_SHIFT
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  input  logic             win_load,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nx;
  logic             start;
  logic             spike_d;
  logic             evt;
  logic             last;
  logic             win_end;
  logic             accept;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] reload;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] final_cnt;
  logic [CNT_W-1:0] new_rate;

  assign evt       = spike_in & ~spike_d;
  assign final_cnt = (evt && count != CNT_MAX) ? count + CNT_W'(1) : count;
  assign reload    = win_len_q - WIN_W'(1);
  assign busy      = (state == COUNT);
  assign win_end   = busy & enable & last;
  assign accept    = rate_valid & rate_ready;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nx = COUNT;
          start    = 1'b1;
        end
      end
      COUNT: begin
        if (!enable)
          state_nx = IDLE;
      end
    endcase
  end

  spike_window_timer #(
    .W(WIN_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .enable(busy & enable),
    .reload(reload),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      spike_d   <= 1'b0;
      win_len_q <= WIN_W'(DEFAULT_WIN);
    end else begin
      spike_d <= spike_in;
      if (win_load)
        win_len_q <= (win_len == '0) ? WIN_W'(1) : win_len;
    end
  end

  // Partial counts are dropped whenever the window is abandoned
  always_ff @(posedge clk) begin
    if (reset || !busy || !enable || win_end)
      count <= '0;
    else
      count <= final_cnt;
  end

`ifdef SPIKE_EMA_EN
  localparam int EW = CNT_W + EMA_SHIFT;

  logic [EW-1:0] ema;
  logic [EW-1:0] ema_nx;

  assign ema_nx   = ema + EW'(final_cnt) - (ema >> EMA_SHIFT);
  assign new_rate = ema_nx[EW-1:EMA_SHIFT];

  always_ff @(posedge clk) begin
    if (reset)
      ema <= '0;
    else if (win_end)
      ema <= ema_nx;
  end
`else
  assign new_rate = final_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_out   <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (win_end) begin
      rate_out   <= new_rate;
      rate_valid <= 1'b1;
      if (rate_valid && !rate_ready)
        overrun <= 1'b1;
    end else if (accept) begin
      rate_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder with a queue scoreboard of window results.
// Expected rates come from an edge-counting model (EMA model if SPIKE_EMA_EN).
module tb_spike_rate_decoder;
  import spike_codec_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 spike_in;
  logic                 enable;
  logic [SPK_WIN_W-1:0] win_len;
  logic                 win_load;
  logic [SPK_CNT_W-1:0] rate_out;
  logic                 rate_valid;
  logic                 rate_ready;
  logic                 overrun;
  logic                 busy;

  int   errors = 0;
  int   checks = 0;
  int   exp_q[$];
  logic prev_sp = 1'b0;
  int   m_ema = 0;

  always #5 clk = ~clk;

  spike_rate_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .spike_in  (spike_in),
    .enable    (enable),
    .win_len   (win_len),
    .win_load  (win_load),
    .rate_out  (rate_out),
    .rate_valid(rate_valid),
    .rate_ready(rate_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic tick();
    prev_sp = spike_in;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_out(int cnt);
`ifdef SPIKE_EMA_EN
    m_ema = m_ema + cnt - (m_ema >> SPK_EMA_SHIFT);
    return m_ema >> SPK_EMA_SHIFT;
`else
    return cnt;
`endif
  endfunction

  task automatic chk_out(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, rate_out, e);
    end
  endtask

  task automatic accept(input string tag);
    chk_out(tag);
    rate_ready = 1'b1;
    tick();
    rate_ready = 1'b0;
    chk({tag, "_clr"}, rate_valid, 0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    spike_in   = 1'b0;
    enable     = 1'b0;
    win_load   = 1'b0;
    rate_ready = 1'b0;
    win_len    = '0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_ema = 0;
  endtask

  task automatic load(input int v);
    win_len  = SPK_WIN_W'(v);
    win_load = 1'b1;
    tick();
    win_load = 1'b0;
  endtask

  task automatic start();
    enable   = 1'b1;
    spike_in = 1'b0;
    tick();
  endtask

  // kind 0: single-cycle pulses on odd cycles below 2*hi; kind 1: high for hi cycles
  task automatic run_win(input int len, input int kind, input int hi,
                         input bit rdy, input bit rdy_last,
                         input int load_at, input int load_val);
    int cnt = 0;
    for (int i = 0; i < len; i++) begin
      logic s;
      s = (kind == 1) ? (i < hi) : ((i < 2 * hi) && (i % 2 == 1));
      spike_in = s;
      if (s && !prev_sp && cnt < (1 << SPK_CNT_W) - 1)
        cnt++;
      rate_ready = rdy || (rdy_last && i == len - 1);
      win_load = (i == load_at);
      if (i == load_at)
        win_len = SPK_WIN_W'(load_val);
      tick();
      if (rdy && i < len - 1)
        chk("win_len_hold", rate_valid, 0);
    end
    win_load   = 1'b0;
    rate_ready = 1'b0;
    spike_in   = 1'b0;
    exp_q.push_back(model_out(cnt));
    chk("win_end_valid", rate_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_rate", rate_out, 0);
    chk("rst_valid", rate_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);

    load(8);
    start();
    chk("busy_on", busy, 1);
    run_win(8, 0, 100, 1, 0, -1, 0);
    enable = 1'b0;
    accept("A_toggle");
    chk("A_idle", busy, 0);

    load(64);
    start();
    run_win(64, 1, 20, 1, 0, -1, 0);
    enable = 1'b0;
    accept("B_hold");

    load(255);
    start();
    run_win(255, 0, 70, 1, 0, -1, 0);
    enable = 1'b0;
    accept("C_sat");

    load(4);
    start();
    run_win(4, 0, 1, 0, 0, -1, 0);
    run_win(4, 0, 100, 0, 0, -1, 0);
    chk("D_overrun", overrun, 1);
    enable = 1'b0;
    void'(exp_q.pop_front());
    accept("D_second");
    chk("D_sticky", overrun, 1);
    do_reset();
    chk("D_rst_overrun", overrun, 0);

    load(4);
    start();
    run_win(4, 0, 2, 0, 0, -1, 0);
    chk_out("E_first");
    run_win(4, 0, 1, 0, 1, -1, 0);
    chk("E_no_overrun", overrun, 0);
    enable = 1'b0;
    accept("E_second");

    load(0);
    start();
    run_win(1, 1, 1, 0, 0, -1, 0);
    enable = 1'b0;
    accept("F_len1");

    load(8);
    start();
    run_win(8, 0, 100, 1, 0, 3, 4);
    chk_out("G_old_len");
    run_win(4, 0, 100, 1, 0, -1, 0);
    enable = 1'b0;
    accept("G_new_len");

    load(16);
    start();
    for (int i = 0; i < 8; i++) begin
      spike_in = (i % 2 == 1) && (i < 6);
      tick();
    end
    enable   = 1'b0;
    spike_in = 1'b0;
    tick();
    chk("H_idle", busy, 0);
    tick();
    tick();
    chk("H_no_result", rate_valid, 0);
    start();
    run_win(16, 0, 2, 1, 0, -1, 0);
    enable = 1'b0;
    accept("H_fresh");

    load(4);
    start();
    run_win(4, 0, 100, 0, 0, -1, 0);
    spike_in = 1'b1;
    tick();
    do_reset();
    chk("I_rate", rate_out, 0);
    chk("I_valid", rate_valid, 0);
    chk("I_overrun", overrun, 0);
    chk("I_busy", busy, 0);

    load(16);
    start();
    for (int w = 0; w < 12; w++) begin
      run_win(16, 0, 100, 1, 0, -1, 0);
      chk_out("J_win");
    end
    enable = 1'b0;
    chk("J_converged", rate_out, 8);
    rate_ready = 1'b1;
    tick();
    rate_ready = 1'b0;
    chk("J_clr", rate_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
